cpu_sequencer: RTL and testbench

Fetch/decode/execute controller for the 8-bit CPU. Reads instruction bytes from program ROM, holds PC and instruction register, and drives the datapath control: the 2-bit A-input select (`reg_sel4`) into the A-register source multiplexer, the register load enables, and the ALU opcode. It sits directly upstream of the A-input multiplexer and the register bank.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/cpu_seq_decode.sv | 96 +++++++++
 rtl/cpu_sequencer.sv | 106 ++++++++++
 tb/tb_cpu_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, sequencer states, A-input select
// codes and ALU operation codes used by the sequencer, the A-input mux and the ALU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_MOVR = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_OPERAND = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_D   = 2'd3;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_SHL    = 3'b101;
  localparam logic [2:0] ALU_SHR    = 3'b110;
  localparam logic [2:0] ALU_PASS_B = 3'b111;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic       ld_a;
    logic       ld_b;
    logic       ld_c;
    logic       ld_d;
    logic [1:0] reg_sel4;
    logic [2:0] alu_op;
    logic       imm_sel;
  } ctrl_t;

  function automatic logic needs_operand(logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

  function automatic logic is_legal(logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational decode for the sequencer: next state, PC update, register-capture
// strobes and the EXEC-cycle datapath controls. CPU_SEQ_TRAP_EN halts on illegal opcodes.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [1:0] state,
  input  logic [7:0] ir,
  input  logic [3:0] fetch_op,
  input  logic       a_zero,
  output ctrl_t      ctrl,
  output logic [1:0] next_state,
  output pc_sel_e    pc_sel,
  output logic       ir_load,
  output logic       imm_load,
  output logic       trap_set
);

  logic unused_field;
  assign unused_field = ir[3];

  always_comb begin
    ctrl       = '0;
    next_state = state;
    pc_sel     = PC_HOLD;
    ir_load    = 1'b0;
    imm_load   = 1'b0;
    trap_set   = 1'b0;

    case (state)
      ST_FETCH: begin
        ir_load = 1'b1;
        pc_sel  = PC_INC;
        // Next state is chosen from the byte being captured, not the stale ir.
        if (needs_operand(fetch_op)) begin
          next_state = ST_OPERAND;
        end else if (fetch_op == OP_HLT) begin
          next_state = ST_HALT;
`ifdef CPU_SEQ_TRAP_EN
        end else if (!is_legal(fetch_op)) begin
          next_state = ST_HALT;
          trap_set   = 1'b1;
`endif
        end else begin
          next_state = ST_EXEC;
        end
      end

      ST_OPERAND: begin
        imm_load   = 1'b1;
        pc_sel     = PC_INC;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        next_state = ST_FETCH;
        case (ir[7:4])
          OP_MOVA: begin
            ctrl.reg_sel4 = ir[1:0];
            ctrl.ld_a     = 1'b1;
          end
          OP_ALU: begin
            ctrl.alu_op   = ir[2:0];
            ctrl.reg_sel4 = SEL_ALU;
            ctrl.ld_a     = 1'b1;
          end
          OP_MOVR: begin
            case (ir[1:0])
              SEL_B:   ctrl.ld_b = 1'b1;
              SEL_C:   ctrl.ld_c = 1'b1;
              SEL_D:   ctrl.ld_d = 1'b1;
              default: ;
            endcase
          end
          OP_LDI: begin
            ctrl.imm_sel  = 1'b1;
            ctrl.alu_op   = ALU_PASS_B;
            ctrl.reg_sel4 = SEL_ALU;
            ctrl.ld_a     = 1'b1;
          end
          OP_JMP: pc_sel = PC_JUMP;
          OP_JZ: begin
            if (a_zero) begin
              pc_sel = PC_JUMP;
            end
          end
          default: ;
        endcase
      end

      ST_HALT: next_state = ST_HALT;

      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller: holds PC, ir and imm and drives datapath controls.
// Define CPU_SEQ_TRAP_EN to stop with a sticky trap on illegal opcodes.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  input  logic            a_zero,
  output logic [1:0]      reg_sel4,
  output logic            ld_a,
  output logic            ld_b,
  output logic            ld_c,
  output logic            ld_d,
  output logic [2:0]      alu_op,
  output logic [7:0]      imm,
  output logic            imm_sel,
  output logic            halted,
  output logic            trap
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q;
  logic [7:0]      imm_q;
  ctrl_t           ctrl, ctrl_g;
  pc_sel_e         pc_sel;
  logic            ir_load, imm_load, trap_set;

  cpu_seq_decode u_decode (
    .state      (state_q),
    .ir         (ir_q),
    .fetch_op   (rom_data[7:4]),
    .a_zero     (a_zero),
    .ctrl       (ctrl),
    .next_state (state_d),
    .pc_sel     (pc_sel),
    .ir_load    (ir_load),
    .imm_load   (imm_load),
    .trap_set   (trap_set)
  );

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:  pc_d = pc_q + PC_W'(1);
      PC_JUMP: pc_d = PC_W'(imm_q);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ir_load) begin
        ir_q <= rom_data;
      end
      if (imm_load) begin
        imm_q <= rom_data;
      end
    end
  end

`ifdef CPU_SEQ_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (trap_set) begin
      trap_q <= 1'b1;
    end
  end

  assign trap = trap_q;
`else
  logic unused_trap_set;
  assign unused_trap_set = trap_set;
  assign trap            = 1'b0;
`endif

  // Reset suppresses every control, so an aborted instruction never loads a register.
  assign ctrl_g   = reset ? '0 : ctrl;

  assign rom_addr = pc_q;
  assign imm      = imm_q;
  assign halted   = (state_q == ST_HALT);
  assign ld_a     = ctrl_g.ld_a;
  assign ld_b     = ctrl_g.ld_b;
  assign ld_c     = ctrl_g.ld_c;
  assign ld_d     = ctrl_g.ld_d;
  assign reg_sel4 = ctrl_g.reg_sel4;
  assign alu_op   = ctrl_g.alu_op;
  assign imm_sel  = ctrl_g.imm_sel;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle outputs, checked against the DUT.
module tb_cpu_sequencer;

  typedef struct packed {
    logic       az;
    logic [7:0] addr;
    logic [3:0] ld;      // {d, c, b, a}
    logic [1:0] sel;
    logic [2:0] alu;
    logic       isel;
    logic [7:0] imm;
    logic       halted;
    logic       trap;
  } exp_t;

`ifdef CPU_SEQ_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rom_addr, rom_data, imm;
  logic       a_zero;
  logic [1:0] reg_sel4;
  logic       ld_a, ld_b, ld_c, ld_d;
  logic [2:0] alu_op;
  logic       imm_sel, halted, trap;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  cpu_sequencer #(
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .a_zero   (a_zero),
    .reg_sel4 (reg_sel4),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_c     (ld_c),
    .ld_d     (ld_d),
    .alu_op   (alu_op),
    .imm      (imm),
    .imm_sel  (imm_sel),
    .halted   (halted),
    .trap     (trap)
  );

  int vectors     = 0;
  int miscompares = 0;

  exp_t       q[$];
  logic [7:0] m_pc, m_imm;
  logic       m_halted, m_trap;
  int         az_mode = 0;  // 0 random, 1 force 0, 2 force 1

  function automatic logic pick_az();
    case (az_mode)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic void model_reset();
    m_pc     = 8'h00;
    m_imm    = 8'h00;
    m_halted = 1'b0;
    m_trap   = 1'b0;
    q.delete();
  endfunction

  // Expand the instruction at m_pc into the cycles it occupies.
  function automatic void build_next();
    exp_t       e;
    logic [3:0] op, fld;
    logic [7:0] pc1;
    logic       illegal, two;
    e      = '0;
    e.imm  = m_imm;
    e.trap = m_trap;
    e.az   = pick_az();
    if (m_halted) begin
      e.addr   = m_pc;
      e.halted = 1'b1;
      q.push_back(e);
      return;
    end
    op      = rom[m_pc][7:4];
    fld     = rom[m_pc][3:0];
    illegal = !((op <= 4'h6) || (op == 4'hF));
    two     = (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
    e.addr  = m_pc;
    q.push_back(e);
    pc1 = m_pc + 8'd1;
    if ((op == 4'hF) || (TrapEn && illegal)) begin
      m_halted = 1'b1;
      m_trap   = illegal;
      m_pc     = pc1;
      return;
    end
    if (two) begin
      e.addr = pc1;
      e.az   = pick_az();
      q.push_back(e);
      m_imm = rom[pc1];
      pc1   = pc1 + 8'd1;
    end
    e      = '0;
    e.imm  = m_imm;
    e.addr = pc1;
    e.az   = pick_az();
    case (op)
      4'h1: begin e.sel = fld[1:0]; e.ld = 4'b0001; end
      4'h2: begin e.alu = fld[2:0]; e.ld = 4'b0001; end
      4'h3: begin
        if (fld[1:0] == 2'd1) e.ld = 4'b0010;
        if (fld[1:0] == 2'd2) e.ld = 4'b0100;
        if (fld[1:0] == 2'd3) e.ld = 4'b1000;
      end
      4'h4: begin e.isel = 1'b1; e.alu = 3'd7; e.ld = 4'b0001; end
      default: ;
    endcase
    q.push_back(e);
    m_pc = ((op == 4'h5) || ((op == 4'h6) && e.az)) ? m_imm : pc1;
  endfunction

  function automatic exp_t next_expected();
    if (q.size() == 0) build_next();
    return q.pop_front();
  endfunction

  function automatic exp_t observe(logic az);
    exp_t o;
    o.az     = az;
    o.addr   = rom_addr;
    o.ld     = {ld_d, ld_c, ld_b, ld_a};
    o.sel    = reg_sel4;
    o.alu    = alu_op;
    o.isel   = imm_sel;
    o.imm    = imm;
    o.halted = halted;
    o.trap   = trap;
    return o;
  endfunction

  function automatic void rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endfunction

  // Called at posedge+1; leaves the DUT in its first post-reset cycle.
  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rom_clear();
    rom[0] = 8'h21;
    reset  = 1'b1;
    a_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ld_d, ld_c, ld_b, ld_a, reg_sel4, alu_op, imm_sel} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0",
               {ld_d, ld_c, ld_b, ld_a, reg_sel4, alu_op, imm_sel});
    end
    vectors++;
    if ({rom_addr, imm, halted, trap} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_regs: addr=%h imm=%h halted=%b trap=%b want all 0",
               rom_addr, imm, halted, trap);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    exp_t e, o;
    for (int p = 0; p < 8; p++) begin
      rom_clear();
      az_mode = 0;
      case (p)
        0: begin rom[0] = 8'h21; rom[1] = 8'h12; end
        1: begin rom[0] = 8'h40; rom[1] = 8'h5A; rom[2] = 8'h33; end
        2: begin rom[0] = 8'h60; rom[1] = 8'h10; az_mode = 2; end
        3: begin rom[0] = 8'h60; rom[1] = 8'h10; az_mode = 1; end
        4: begin rom[0] = 8'h50; rom[1] = 8'hFF; rom[8'hFF] = 8'h50; rom[8'h50] = 8'h3B; end
        5: rom[0] = 8'hF0;
        6: rom[0] = 8'h90;
        default: begin rom[8'h00] = 8'h50; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'h1F; end
      endcase
      apply_reset();
      for (int c = 1; c <= 12; c++) begin
        e      = next_expected();
        a_zero = e.az;
        @(negedge clk);
        o = observe(e.az);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL directed%0d cycle%0d: got %h want %h", p, c, o, e);
        end
        @(posedge clk);
        #1;
      end
    end
    az_mode = 0;
  endtask

  task automatic test_reset_abort();
    exp_t e, o;
    for (int s = 0; s < 3; s++) begin
      rom_clear();
      case (s)
        0: begin rom[0] = 8'h40; rom[1] = 8'h5A; rom[2] = 8'h33; end
        1: rom[0] = 8'h21;
        default: rom[0] = 8'hF0;
      endcase
      apply_reset();
      for (int c = 1; c <= 6; c++) begin
        // Scenario 0/1: reset lands in the OPERAND / EXEC cycle; 2: after HALT.
        if ((s == 0 && c == 2) || (s == 1 && c == 2) || (s == 2 && c == 5)) begin
          reset  = 1'b1;
          a_zero = 1'b1;
          @(negedge clk);
          vectors++;
          if ({ld_d, ld_c, ld_b, ld_a} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_abort%0d ld: got %b want 0000", s, {ld_d, ld_c, ld_b, ld_a});
          end
          @(posedge clk);
          #1 reset = 1'b0;
          model_reset();
        end
        e      = next_expected();
        a_zero = e.az;
        @(negedge clk);
        o = observe(e.az);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL reset_abort%0d cycle%0d: got %h want %h", s, c, o, e);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_random();
    exp_t       e, o;
    logic [7:0] b;
    int         r;
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom());
        r = $urandom_range(0, 19);
        if (r == 0)      b[7:4] = 4'hF;
        else if (r == 1) b[7:4] = 4'($urandom_range(7, 14));
        else             b[7:4] = 4'($urandom_range(0, 6));
        rom[i] = b;
      end
      apply_reset();
      for (int c = 1; c <= 120; c++) begin
        e      = next_expected();
        a_zero = e.az;
        @(negedge clk);
        o = observe(e.az);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL random%0d cycle%0d: got %h want %h", p, c, o, e);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
